inst_buffer: RTL
================

INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning the number of instruction entries; it SHALL be a power of two and at least 2.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port flush, input, 1 bit: discard all buffered instructions (mispredict/exception recovery).
REQ-005 The module SHALL have port in_valid, input, 1 bit: fetch presents an instruction.
REQ-006 The module SHALL have port in_inst, input, 32 bits (INST): fetched instruction word.
REQ-007 The module SHALL have port in_pc, input, XLEN bits: PC of in_inst.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the buffer can accept an instruction this cycle.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the head entry is valid and is presented to the decoder.
REQ-010 The module SHALL have port out_inst, output, 32 bits (INST): head instruction word, driving decoder inst.
REQ-011 The module SHALL have port out_pc, output, XLEN bits: head PC, driving decoder in_pc.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the decoder/dispatch consumes the head this cycle.
REQ-013 The module SHALL have port count, output, $clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-014 Circular FIFO: storage of DEPTH {inst, pc} entries, head pointer, tail pointer, occupancy counter.
REQ-015 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend on out_ready; there is no pop-to-push passthrough when full.
REQ-016 out_valid SHALL equal (count != 0); out_inst and out_pc SHALL be the head entry when out_valid=1, and all-zero when out_valid=0.
REQ-017 Push = in_valid & in_ready & ~flush; the entry is written at the tail and the tail advances by 1 modulo DEPTH.
REQ-018 Pop = out_valid & out_ready & ~flush; the head advances by 1 modulo DEPTH.
REQ-019 count: push only SHALL add 1; pop only SHALL subtract 1; push and pop in the same cycle SHALL leave it unchanged.
REQ-020 Latency: a pushed entry SHALL first appear on the outputs the cycle after the push; there is no empty-buffer bypass.
REQ-021 Order SHALL be strictly FIFO across pointer wrap-around from DEPTH-1 to 0.
REQ-022 in_valid while full SHALL be ignored, with no state change; fetch holds the instruction.
REQ-023 out_ready while empty SHALL be ignored.
REQ-024 flush SHALL take priority: at the next edge head=tail=0 and count=0, and any same-cycle push and pop are discarded.
REQ-025 Entry storage contents SHALL NOT be cleared by flush; only the pointers and the counter are cleared.

Reset
REQ-026 reset_n=0 SHALL asynchronously force head=0, tail=0, count=0, hence out_valid=0, in_ready=1, out_inst=0, out_pc=0, including mid-operation.
REQ-027 After reset_n deasserts, the first push SHALL be accepted at the first rising edge.

Structure
REQ-028 DEPTH default SHALL be constant IBUF_DEPTH in sys_defs.svh; XLEN and the INST type come from the shared definitions.
REQ-029 The block SHALL be self-contained with no sub-module; the pointer-width localparam is derived from DEPTH.

Verification
REQ-030 Reset, then push PCs 0x0,0x4,0x8 with out_ready=0 -> count=3 and out_pc=0x0; then set out_ready=1 -> out_pc sequence is 0x0,0x4,0x8, then out_valid=0.
REQ-031 Push 8 entries with no pop -> in_ready=0 and count=8; a ninth in_valid is ignored; pop+push in one cycle while full -> only the pop takes effect, count=7.
REQ-032 Continuous push+pop for 20 cycles with PCs 0x100 upward by 4 -> no loss or reordering across wrap-around, and count stays constant.
REQ-033 With 5 entries, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, in_ready=1; the next push appears the following cycle.
REQ-034 Assert reset_n low between edges with 4 entries -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
REQ-035 Empty buffer, push inst 0x00000013 at PC 0x20 -> out_valid=0 in the push cycle; out_valid=1, out_inst=0x00000013, out_pc=0x20 the next cycle.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : inst_buffer_pkg
// Description : Shared widths, default depth and entry type for the
//               fetch-to-decode instruction buffer.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package inst_buffer_pkg;

  localparam int XLEN       = 32;
  localparam int IBUF_DEPTH = 8;

  typedef logic [31:0] inst_t;

  typedef struct packed {
    inst_t           inst;
    logic [XLEN-1:0] pc;
  } ibuf_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : inst_buffer
// Description : Circular FIFO of {inst, pc} entries between fetch and decode,
//               with flush recovery and a registered (non-bypassed) head.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  inst_t                        in_inst,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         in_ready,
  output logic                         out_valid,
  output inst_t                        out_inst,
  output logic [XLEN-1:0]              out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  ibuf_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Full blocks fetch even when the head is being consumed: no passthrough.
  always_comb begin
    in_ready  = (count_q < CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never cleared; only pointers and the counter are.
  always_ff @(posedge clock) begin
    if (push) mem_q[tail_q] <= '{inst: in_inst, pc: in_pc};
  end

  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (out_valid) begin
      out_inst = mem_q[head_q].inst;
      out_pc   = mem_q[head_q].pc;
    end
    count = count_q;
  end

endmodule
`default_nettype wire
